// File: rtl/fact_engine_if.sv
// Handshake/result bundle for the iterative factorial unit.
interface fact_engine_if #(
  parameter int N_W = 4,
  parameter int P_W = 32
);
  logic           go;
  logic [N_W-1:0] n;
  logic           busy;
  logic           done;
  logic           err;
  logic [P_W-1:0] product;

  modport master (output go, n, input busy, done, err, product);
  modport slave  (input go, n, output busy, done, err, product);
endinterface

// File: rtl/fact_engine.sv
// Iterative factorial unit: one multiply per cycle, go/done handshake,
// range and product-overflow flagging. Datapath and FSM in one block.
module fact_engine #(
  parameter int N_W   = 4,
  parameter int P_W   = 32,
  parameter int MAX_N = 12
) (
  input  logic         clk,
  input  logic         rst,
  fact_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t               state, state_nx;
  logic [N_W-1:0]       cnt, cnt_nx;
  logic [P_W-1:0]       product_q, product_nx;
  logic                 err_q, err_nx;
  logic                 done_q, busy_q;
  logic [P_W+N_W-1:0]   full;

  // Full-width product so overflow is seen even if MAX_N is set too large.
  assign full = {{N_W{1'b0}}, product_q} * {{P_W{1'b0}}, cnt};

  // Next-state and datapath update selection.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    product_nx = product_q;
    err_nx     = err_q;
    case (state)
      IDLE: begin
        if (bus.go) begin
          if (32'(bus.n) > MAX_N) begin
            err_nx     = 1'b1;
            product_nx = '0;
            state_nx   = DONE;
          end else begin
            cnt_nx     = bus.n;
            product_nx = P_W'(1);
            err_nx     = 1'b0;
            state_nx   = MULT;
          end
        end
      end
      MULT: begin
        if (cnt <= N_W'(1)) begin
          state_nx = DONE;
        end else if (full[P_W+N_W-1:P_W] != '0) begin
          err_nx     = 1'b1;
          product_nx = '0;
          state_nx   = DONE;
        end else begin
          product_nx = full[P_W-1:0];
          cnt_nx     = cnt - N_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered status flags; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      product_q <= product_nx;
      err_q     <= err_nx;
      done_q    <= (state_nx == DONE);
      busy_q    <= (state_nx == MULT);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.product = product_q;

endmodule
